// File: rtl/adxl362_pkg.sv
// Shared types and constants for the ADXL362 register-file arbiter.
package adxl362_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;

  localparam logic GNT_SPI = 1'b0;
  localparam logic GNT_SMP = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } arb_state_e;

endpackage

// File: rtl/adxl362_arb_pick.sv
// Combinational winner selection: SPI has priority unless the sample engine has waited MAX_WAIT grants.
module adxl362_arb_pick
  import adxl362_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic       spi_req_i,
  input  logic       smp_req_i,
  input  logic [3:0] wait_cnt_i,
  output logic       winner_o,
  output logic       valid_o
);

  assign valid_o = spi_req_i | smp_req_i;

  always_comb begin
    winner_o = GNT_SPI;
    if (smp_req_i && (!spi_req_i || (wait_cnt_i == 4'(MAX_WAIT))))
      winner_o = GNT_SMP;
  end

endmodule

// File: rtl/adxl362_reg_arbiter.sv
// Single-port register-file arbiter between the SPI decoder and the sample engine.
// One transaction at a time through IDLE -> ACCESS -> CAPTURE -> ACK.
module adxl362_reg_arbiter
  import adxl362_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_16mhz,
  input  logic              reset,
  input  logic              spi_req,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic              spi_ack,
  output logic [DATA_W-1:0] spi_rdata,
  input  logic              smp_req,
  input  logic              smp_we,
  input  logic [ADDR_W-1:0] smp_addr,
  input  logic [DATA_W-1:0] smp_wdata,
  output logic              smp_ack,
  output logic [DATA_W-1:0] smp_rdata,
  output logic              rf_en,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy,
  output logic              grant_id
);

  arb_state_e        state_q;
  logic              rf_en_q, rf_we_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              spi_ack_q, smp_ack_q;
  logic [DATA_W-1:0] spi_rdata_q, smp_rdata_q;
  logic              grant_q;
  logic [3:0]        wait_q, wait_d;
  logic              win, win_vld;

  adxl362_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
    .spi_req_i (spi_req),
    .smp_req_i (smp_req),
    .wait_cnt_i(wait_q),
    .winner_o  (win),
    .valid_o   (win_vld)
  );

  // Age counter: only SPI grants taken while SMP is waiting count against it.
  always_comb begin
    wait_d = wait_q;
    if (win == GNT_SMP)
      wait_d = '0;
    else if (smp_req && (wait_q != 4'(MAX_WAIT)))
      wait_d = wait_q + 4'd1;
  end

  always_ff @(posedge clk_16mhz) begin
    if (reset) begin
      state_q     <= IDLE;
      rf_en_q     <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_wdata_q  <= '0;
      spi_ack_q   <= 1'b0;
      smp_ack_q   <= 1'b0;
      spi_rdata_q <= '0;
      smp_rdata_q <= '0;
      grant_q     <= GNT_SPI;
      wait_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            grant_q    <= win;
            rf_we_q    <= (win == GNT_SMP) ? smp_we    : spi_we;
            rf_addr_q  <= (win == GNT_SMP) ? smp_addr  : spi_addr;
            rf_wdata_q <= (win == GNT_SMP) ? smp_wdata : spi_wdata;
            rf_en_q    <= 1'b1;
            wait_q     <= wait_d;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          rf_en_q <= 1'b0;
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          // Writes return zero so a stale read value never looks fresh.
          if (grant_q == GNT_SPI) begin
            spi_rdata_q <= rf_we_q ? '0 : rf_rdata;
            spi_ack_q   <= 1'b1;
          end else begin
            smp_rdata_q <= rf_we_q ? '0 : rf_rdata;
            smp_ack_q   <= 1'b1;
          end
          state_q <= ACK;
        end
        ACK: begin
          spi_ack_q <= 1'b0;
          smp_ack_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rf_en     = rf_en_q;
  assign rf_we     = rf_we_q;
  assign rf_addr   = rf_addr_q;
  assign rf_wdata  = rf_wdata_q;
  assign spi_ack   = spi_ack_q;
  assign smp_ack   = smp_ack_q;
  assign spi_rdata = spi_rdata_q;
  assign smp_rdata = smp_rdata_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adxl362_reg_arbiter.sv
// Bench for adxl362_reg_arbiter: directed vector table, corner sequences, and random traffic vs a transaction model.
module tb_adxl362_reg_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;
  localparam int MW = 4;

  logic          clk_16mhz = 1'b0;
  logic          reset = 1'b1;
  logic          spi_req = 1'b0, spi_we = 1'b0;
  logic [AW-1:0] spi_addr = '0;
  logic [DW-1:0] spi_wdata = '0;
  logic          spi_ack;
  logic [DW-1:0] spi_rdata;
  logic          smp_req = 1'b0, smp_we = 1'b0;
  logic [AW-1:0] smp_addr = '0;
  logic [DW-1:0] smp_wdata = '0;
  logic          smp_ack;
  logic [DW-1:0] smp_rdata;
  logic          rf_en, rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata;
  logic          busy, grant_id;

  int total = 0;
  int bad = 0;

  adxl362_reg_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk_16mhz(clk_16mhz), .reset(reset),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_ack(spi_ack), .spi_rdata(spi_rdata),
    .smp_req(smp_req), .smp_we(smp_we), .smp_addr(smp_addr), .smp_wdata(smp_wdata),
    .smp_ack(smp_ack), .smp_rdata(smp_rdata),
    .rf_en(rf_en), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata), .busy(busy), .grant_id(grant_id)
  );

  always #31 clk_16mhz = ~clk_16mhz;

  // Register file model: read data appears the cycle after rf_en.
  logic [DW-1:0] rfmem [64];
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  always @(posedge clk_16mhz) begin
    if (pl_we) rfmem[pl_addr] <= pl_data;
    if (rf_en) begin
      if (rf_we) rfmem[rf_addr] <= rf_wdata;
      rf_rdata <= rfmem[rf_addr];
    end
  end

  task automatic step();
    @(posedge clk_16mhz);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    step();
    pl_we   = 1'b0;
  endtask

  task automatic drop_all();
    spi_req = 1'b0;
    smp_req = 1'b0;
  endtask

  typedef struct {
    logic          who;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          pre;
    logic [DW-1:0] mem;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  task automatic apply_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    if (v.pre) preload(v.addr, v.mem);
    if (v.who == 1'b0) begin
      spi_we = v.we; spi_addr = v.addr; spi_wdata = v.wdata; spi_req = 1'b1;
    end else begin
      smp_we = v.we; smp_addr = v.addr; smp_wdata = v.wdata; smp_req = 1'b1;
    end
    step();
    chk({s, "_c1_rf_en"},  32'(rf_en), 32'd1);
    chk({s, "_c1_rf_we"},  32'(rf_we), 32'(v.we));
    chk({s, "_c1_rf_addr"}, 32'(rf_addr), 32'(v.addr));
    chk({s, "_c1_rf_wdata"}, 32'(rf_wdata), 32'(v.wdata));
    chk({s, "_c1_busy"},   32'(busy), 32'd1);
    chk({s, "_c1_grant"},  32'(grant_id), 32'(v.who));
    step();
    chk({s, "_c2_rf_en"},  32'(rf_en), 32'd0);
    chk({s, "_c2_acks"},   32'({spi_ack, smp_ack}), 32'd0);
    step();
    chk({s, "_c3_spi_ack"}, 32'(spi_ack), 32'(!v.who));
    chk({s, "_c3_smp_ack"}, 32'(smp_ack), 32'(v.who));
    chk({s, "_c3_rdata"}, 32'(v.who ? smp_rdata : spi_rdata), 32'(v.exp_rdata));
    chk({s, "_c3_busy"},   32'(busy), 32'd1);
    drop_all();
    step();
    chk({s, "_c4_busy"},   32'(busy), 32'd0);
    chk({s, "_c4_acks"},   32'({spi_ack, smp_ack, rf_en}), 32'd0);
  endtask

  vec_t vt [6];

  // Random-phase reference model state (one outstanding transaction at most).
  logic [DW-1:0] gmem [64];
  bit            have;
  int            g, starve;
  logic          gwho, gwe;
  logic [AW-1:0] gaddr;
  logic [DW-1:0] gwdata, grdata, last_spi, last_smp;

  initial begin
    #(62 * 60000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nen, nack, ng;
    logic seq [10];

    vt[0] = '{who:1'b0, we:1'b0, addr:6'h00, wdata:8'h11, pre:1'b1, mem:8'hAD, exp_rdata:8'hAD};
    vt[1] = '{who:1'b1, we:1'b1, addr:6'h08, wdata:8'h5A, pre:1'b1, mem:8'h33, exp_rdata:8'h00};
    vt[2] = '{who:1'b1, we:1'b0, addr:6'h3F, wdata:8'h00, pre:1'b1, mem:8'hFF, exp_rdata:8'hFF};
    vt[3] = '{who:1'b0, we:1'b1, addr:6'h3F, wdata:8'h00, pre:1'b1, mem:8'h77, exp_rdata:8'h00};
    vt[4] = '{who:1'b0, we:1'b0, addr:6'h08, wdata:8'hC3, pre:1'b0, mem:8'h00, exp_rdata:8'h5A};
    vt[5] = '{who:1'b1, we:1'b0, addr:6'h15, wdata:8'hE7, pre:1'b1, mem:8'h01, exp_rdata:8'h01};

    // Reset state
    step(); step();
    chk("rst_outputs", 32'({rf_en, rf_we, rf_addr, rf_wdata}), 32'd0);
    chk("rst_acks", 32'({spi_ack, smp_ack, busy, grant_id}), 32'd0);
    chk("rst_rdata", 32'({spi_rdata, smp_rdata}), 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) apply_vec(vt[i], i);

    // Simultaneous requests with no accumulated wait: SPI first, SMP next.
    spi_we = 1'b0; spi_addr = 6'h00; spi_req = 1'b1;
    smp_we = 1'b0; smp_addr = 6'h3F; smp_req = 1'b1;
    step();
    chk("sim_c1_grant", 32'(grant_id), 32'd0);
    chk("sim_c1_rf_en", 32'(rf_en), 32'd1);
    step(); step();
    chk("sim_c3_spi_ack", 32'({spi_ack, smp_ack}), 32'b10);
    chk("sim_c3_spi_rdata", 32'(spi_rdata), 32'hAD);
    spi_req = 1'b0;
    step();
    chk("sim_c4_idle", 32'({busy, rf_en}), 32'd0);
    step();
    chk("sim_c5_rf_en", 32'(rf_en), 32'd1);
    chk("sim_c5_grant", 32'(grant_id), 32'd1);
    chk("sim_c5_addr", 32'(rf_addr), 32'h3F);
    step(); step();
    chk("sim_c7_smp_ack", 32'({spi_ack, smp_ack}), 32'b01);
    chk("sim_c7_smp_rdata", 32'(smp_rdata), 32'h00);
    drop_all();
    step(); step();

    // Starvation guard: both held high; expect MW SPI grants then one SMP, repeating.
    spi_we = 1'b0; spi_addr = 6'h00; spi_req = 1'b1;
    smp_we = 1'b0; smp_addr = 6'h08; smp_req = 1'b1;
    ng = 0;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      step();
      if (rf_en) begin
        seq[ng] = grant_id;
        ng++;
      end
    end
    if (ng < 10) chk("starve_grants", 32'(ng), 32'd10);
    for (int k = 0; k < ng; k++)
      chk($sformatf("starve_g%0d", k), 32'(seq[k]), 32'((k % (MW + 1)) == MW));
    drop_all();
    for (int c = 0; c < 6; c++) step();

    // Reset during CAPTURE aborts; the held request is re-arbitrated.
    spi_we = 1'b0; spi_addr = 6'h00; spi_req = 1'b1;
    step();
    chk("rc_c1_rf_en", 32'(rf_en), 32'd1);
    step();
    reset = 1'b1;
    step();
    chk("rc_c3_ctrl", 32'({spi_ack, smp_ack, rf_en, busy, grant_id, rf_we}), 32'd0);
    chk("rc_c3_data", 32'({rf_addr, rf_wdata, spi_rdata, smp_rdata}), 32'd0);
    reset = 1'b0;
    step();
    chk("rc_c4_rf_en", 32'(rf_en), 32'd1);
    step(); step();
    chk("rc_c6_ack", 32'(spi_ack), 32'd1);
    chk("rc_c6_rdata", 32'(spi_rdata), 32'hAD);
    drop_all();
    step(); step();

    // ACK-cycle hold: req stays high through ack, dropped the cycle after.
    spi_we = 1'b0; spi_addr = 6'h08; spi_req = 1'b1;
    nen = 0; nack = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (rf_en) nen++;
      if (spi_ack) nack++;
      if (c == 4) spi_req = 1'b0;
    end
    chk("hold_rf_en_count", 32'(nen), 32'd1);
    chk("hold_ack_count", 32'(nack), 32'd1);

    // Random traffic against a transaction-level model.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int a = 0; a < 64; a++) begin
      gmem[a] = 8'($urandom);
      preload(6'(a), gmem[a]);
    end
    have = 1'b0; g = 0; starve = 0; last_spi = '0; last_smp = '0;
    gwho = 1'b0; gwe = 1'b0; gaddr = '0; gwdata = '0; grdata = '0;
    for (int t = 0; t < 600; t++) begin
      step();
      chk("r_rf_en", 32'(rf_en), 32'(have && t == g + 1));
      if (have && t == g + 1) begin
        chk("r_rf_we", 32'(rf_we), 32'(gwe));
        chk("r_rf_addr", 32'(rf_addr), 32'(gaddr));
        chk("r_rf_wdata", 32'(rf_wdata), 32'(gwdata));
      end
      chk("r_busy", 32'(busy), 32'(have && t >= g + 1 && t <= g + 3));
      if (have && t >= g + 1 && t <= g + 3) chk("r_grant", 32'(grant_id), 32'(gwho));
      chk("r_spi_ack", 32'(spi_ack), 32'(have && t == g + 3 && !gwho));
      chk("r_smp_ack", 32'(smp_ack), 32'(have && t == g + 3 && gwho));
      if (have && t == g + 3) begin
        if (gwho) last_smp = grdata; else last_spi = grdata;
      end
      chk("r_spi_rdata", 32'(spi_rdata), 32'(last_spi));
      chk("r_smp_rdata", 32'(smp_rdata), 32'(last_smp));

      if (have && t == g + 3 && !gwho) spi_req = 1'b0;
      if (have && t == g + 3 && gwho)  smp_req = 1'b0;
      if (!spi_req && $urandom_range(0, 2) == 0) begin
        spi_we = 1'($urandom); spi_addr = 6'($urandom); spi_wdata = 8'($urandom); spi_req = 1'b1;
      end
      if (!smp_req && $urandom_range(0, 2) == 0) begin
        smp_we = 1'($urandom); smp_addr = 6'($urandom); smp_wdata = 8'($urandom); smp_req = 1'b1;
      end

      if ((!have || t >= g + 4) && (spi_req || smp_req)) begin
        gwho = !(spi_req && !(smp_req && starve >= MW));
        if (!gwho && smp_req) starve++;
        if (gwho) starve = 0;
        gwe    = gwho ? smp_we : spi_we;
        gaddr  = gwho ? smp_addr : spi_addr;
        gwdata = gwho ? smp_wdata : spi_wdata;
        grdata = gwe ? 8'h00 : gmem[gaddr];
        if (gwe) gmem[gaddr] = gwdata;
        g = t;
        have = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
